// File: rtl/block_ram_nrw_if.sv
// Request/response bundle for block_ram_nrw: one request and one response
// channel per port, each with valid and backpressure.
interface block_ram_nrw_if #(
  parameter int Width     = 8,
  parameter int AddrWidth = 8,
  parameter int NumPorts  = 2
);
  // Request word per port: {addr, wdata, wr}
  logic [NumPorts-1:0][Width+AddrWidth:0] req;
  logic [NumPorts-1:0]                    req_valid;
  logic [NumPorts-1:0]                    req_bp;
  logic [NumPorts-1:0][Width-1:0]         resp;
  logic [NumPorts-1:0]                    resp_valid;
  logic [NumPorts-1:0]                    resp_bp;

  modport master (
    output req, req_valid, resp_bp,
    input  req_bp, resp, resp_valid
  );

  modport slave (
    input  req, req_valid, resp_bp,
    output req_bp, resp, resp_valid
  );
endinterface

// File: rtl/block_ram_nrw.sv
// N-port block RAM with one-cycle registered responses held under
// backpressure, lowest-port-wins write arbitration and selectable
// read-during-write behaviour (read-first or write-first).
module block_ram_nrw #(
  parameter string Name       = "",
  parameter int    Width      = 8,
  parameter int    Depth      = 8,
  parameter int    AddrWidth  = 8,
  parameter int    NumPorts   = 2,
  parameter int    WriteFirst = 0
) (
  input logic           clk,
  input logic           resetn,
  block_ram_nrw_if.slave bus
);

  localparam int IdxW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [AddrWidth:0] DepthLim = (AddrWidth+1)'(Depth);

  logic [Width-1:0] mem_q [Depth];

  logic [NumPorts-1:0][AddrWidth-1:0] addr;
  logic [NumPorts-1:0][IdxW-1:0]      idx;
  logic [NumPorts-1:0][Width-1:0]     wdata;
  logic [NumPorts-1:0]                in_rng;
  logic [NumPorts-1:0]                req_bp_int;
  logic [NumPorts-1:0]                acc;
  logic [NumPorts-1:0]                wr_en;
  logic [NumPorts-1:0]                win;
  logic [NumPorts-1:0]                fwd_hit;
  logic [NumPorts-1:0][Width-1:0]     fwd_data;
  logic [NumPorts-1:0][Width-1:0]     rdata;
  logic [NumPorts-1:0][Width-1:0]     resp_d, resp_q;
  logic [NumPorts-1:0]                resp_valid_d, resp_valid_q;

  // Stall a port while reset is active or its held response is blocked.
  assign req_bp_int = {NumPorts{~resetn}} | (resp_valid_q & bus.resp_bp);
  assign bus.req_bp = req_bp_int;

  // Split request words and qualify accepts and in-range writes.
  always_comb begin
    addr   = '0;
    idx    = '0;
    wdata  = '0;
    in_rng = '0;
    acc    = '0;
    wr_en  = '0;
    for (int unsigned p = 0; p < NumPorts; p++) begin
      addr[p]   = bus.req[p][Width+AddrWidth:Width+1];
      wdata[p]  = bus.req[p][Width:1];
      idx[p]    = addr[p][IdxW-1:0];
      in_rng[p] = ({1'b0, addr[p]} < DepthLim);
      acc[p]    = resetn & bus.req_valid[p] & ~req_bp_int[p];
      wr_en[p]  = acc[p] & bus.req[p][0] & in_rng[p];
    end
  end

  // A write loses to any lower-indexed write targeting the same address.
  always_comb begin
    win = wr_en;
    for (int unsigned p = 1; p < NumPorts; p++) begin
      for (int unsigned q = 0; q < p; q++) begin
        if (wr_en[q] && (addr[q] == addr[p])) begin
          win[p] = 1'b0;
        end
      end
    end
  end

  // Find the winning write data for each port's address this cycle.
  always_comb begin
    fwd_hit  = '0;
    fwd_data = '0;
    for (int unsigned p = 0; p < NumPorts; p++) begin
      for (int unsigned q = 0; q < NumPorts; q++) begin
        if (!fwd_hit[p] && wr_en[q] && (addr[q] == addr[p])) begin
          fwd_hit[p]  = 1'b1;
          fwd_data[p] = wdata[q];
        end
      end
    end
  end

  // Response data: zero out of range, else array word or forwarded write.
  always_comb begin
    rdata = '0;
    for (int unsigned p = 0; p < NumPorts; p++) begin
      if (in_rng[p]) begin
        if ((WriteFirst != 0) && fwd_hit[p]) begin
          rdata[p] = fwd_data[p];
        end else begin
          rdata[p] = mem_q[idx[p]];
        end
      end
    end
  end

  // Response register next state: load on accept, drain when not blocked.
  always_comb begin
    resp_d       = resp_q;
    resp_valid_d = resp_valid_q;
    for (int unsigned p = 0; p < NumPorts; p++) begin
      if (acc[p]) begin
        resp_d[p]       = rdata[p];
        resp_valid_d[p] = 1'b1;
      end else if (!bus.resp_bp[p]) begin
        resp_valid_d[p] = 1'b0;
      end
    end
  end

  // Response registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      resp_q       <= '0;
      resp_valid_q <= '0;
    end else begin
      resp_q       <= resp_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  // Array update; winners always hit distinct addresses, so order is moot.
  always_ff @(posedge clk) begin
    for (int unsigned p = 0; p < NumPorts; p++) begin
      if (win[p]) begin
        mem_q[idx[p]] <= wdata[p];
      end
    end
  end

  assign bus.resp       = resp_q;
  assign bus.resp_valid = resp_valid_q;

endmodule

// File: tb/tb_block_ram_nrw.sv
module tb_block_ram_nrw;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn;
  int unsigned errors = 0;
  int unsigned checks = 0;

  block_ram_nrw_if #(.Width(8), .AddrWidth(8), .NumPorts(2)) if0 ();
  block_ram_nrw_if #(.Width(8), .AddrWidth(8), .NumPorts(2)) if1 ();
  block_ram_nrw_if #(.Width(8), .AddrWidth(3), .NumPorts(2)) if2 ();

  block_ram_nrw #(.Name("rf"), .Width(8), .Depth(8), .AddrWidth(8), .NumPorts(2), .WriteFirst(0))
    dut0 (.clk(clk), .resetn(resetn), .bus(if0));
  block_ram_nrw #(.Name("wf"), .Width(8), .Depth(8), .AddrWidth(8), .NumPorts(2), .WriteFirst(1))
    dut1 (.clk(clk), .resetn(resetn), .bus(if1));
  block_ram_nrw #(.Name("d6"), .Width(8), .Depth(6), .AddrWidth(3), .NumPorts(2), .WriteFirst(0))
    dut2 (.clk(clk), .resetn(resetn), .bus(if2));

  // Stimulus state per dut/port
  logic       v  [3][2];
  logic       w  [3][2];
  logic       bp [3][2];
  logic [7:0] ad [3][2];
  logic [7:0] wd [3][2];

  assign if0.req = {{ad[0][1], wd[0][1], w[0][1]}, {ad[0][0], wd[0][0], w[0][0]}};
  assign if1.req = {{ad[1][1], wd[1][1], w[1][1]}, {ad[1][0], wd[1][0], w[1][0]}};
  assign if2.req = {{ad[2][1][2:0], wd[2][1], w[2][1]}, {ad[2][0][2:0], wd[2][0], w[2][0]}};
  assign if0.req_valid = {v[0][1], v[0][0]};
  assign if1.req_valid = {v[1][1], v[1][0]};
  assign if2.req_valid = {v[2][1], v[2][0]};
  assign if0.resp_bp = {bp[0][1], bp[0][0]};
  assign if1.resp_bp = {bp[1][1], bp[1][0]};
  assign if2.resp_bp = {bp[2][1], bp[2][0]};

  logic [1:0][7:0] rd_w [3];
  logic [1:0]      rv_w [3];
  logic [1:0]      rb_w [3];
  assign rd_w[0] = if0.resp;       assign rd_w[1] = if1.resp;       assign rd_w[2] = if2.resp;
  assign rv_w[0] = if0.resp_valid; assign rv_w[1] = if1.resp_valid; assign rv_w[2] = if2.resp_valid;
  assign rb_w[0] = if0.req_bp;     assign rb_w[1] = if1.req_bp;     assign rb_w[2] = if2.req_bp;

  // Reference model: contents with known flags, response-valid, scoreboard
  logic [7:0]  mem_m   [3][8];
  bit          known_m [3][8];
  int unsigned depth_m [3] = '{8, 8, 6};
  bit          wf_m    [3] = '{1'b0, 1'b1, 1'b0};
  bit          mv      [3][2];
  bit          acc_m   [3][2];
  logic [8:0]  held    [3][2];   // {known, data}
  logic [8:0]  sbq     [3][2][$];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    for (int d = 0; d < 3; d++) begin
      for (int p = 0; p < 2; p++) begin
        v[d][p] = 1'b0; w[d][p] = 1'b0; bp[d][p] = 1'b0;
        ad[d][p] = 8'h00; wd[d][p] = 8'h00;
      end
    end
  endtask

  task automatic set(input int d, input int p, input logic wr, input logic [7:0] a, input logic [7:0] dt);
    v[d][p] = 1'b1; w[d][p] = wr; ad[d][p] = a; wd[d][p] = dt;
  endtask

  // One clock: model the accepts, push expected responses, then pop and
  // compare against every port just after the edge.
  task automatic tick();
    logic [7:0] r;
    bit         rk;
    bit         found;
    logic [8:0] e;
    for (int d = 0; d < 3; d++) begin
      for (int p = 0; p < 2; p++) begin
        acc_m[d][p] = resetn && v[d][p] && !(mv[d][p] && bp[d][p]);
      end
      for (int p = 0; p < 2; p++) begin
        if (acc_m[d][p]) begin
          if (ad[d][p] >= depth_m[d]) begin
            r = 8'h00; rk = 1'b1;
          end else begin
            r = mem_m[d][ad[d][p]]; rk = known_m[d][ad[d][p]];
            found = 1'b0;
            if (wf_m[d]) begin
              for (int q = 0; q < 2; q++) begin
                if (!found && acc_m[d][q] && w[d][q] && (ad[d][q] < depth_m[d]) && (ad[d][q] == ad[d][p])) begin
                  found = 1'b1; r = wd[d][q]; rk = 1'b1;
                end
              end
            end
          end
          sbq[d][p].push_back({rk, r});
        end
      end
      for (int q = 1; q >= 0; q--) begin
        if (acc_m[d][q] && w[d][q] && (ad[d][q] < depth_m[d])) begin
          mem_m[d][ad[d][q]] = wd[d][q];
          known_m[d][ad[d][q]] = 1'b1;
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (!resetn) begin
          mv[d][p] = 1'b0;
          sbq[d][p].delete();
          held[d][p] = 9'h100;
        end else if (acc_m[d][p]) begin
          mv[d][p] = 1'b1;
        end else if (!bp[d][p]) begin
          mv[d][p] = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      for (int p = 0; p < 2; p++) begin
        if (acc_m[d][p]) begin
          e = sbq[d][p].pop_front();
          held[d][p] = e;
        end
        chk($sformatf("resp_valid d%0dp%0d", d, p), {7'b0, rv_w[d][p]}, {7'b0, mv[d][p]});
        chk($sformatf("req_bp d%0dp%0d", d, p), {7'b0, rb_w[d][p]},
            {7'b0, (!resetn || (mv[d][p] && bp[d][p]))});
        if (held[d][p][8]) begin
          chk($sformatf("resp d%0dp%0d", d, p), rd_w[d][p], held[d][p][7:0]);
        end
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      for (int a = 0; a < 8; a++) begin
        mem_m[d][a] = 8'h00; known_m[d][a] = 1'b0;
      end
      for (int p = 0; p < 2; p++) begin
        mv[d][p] = 1'b0; acc_m[d][p] = 1'b0; held[d][p] = 9'h100;
      end
    end
    clr();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;

    // Preload every location with 0x10+addr on all instances
    for (int a = 0; a < 8; a++) begin
      clr();
      for (int d = 0; d < 3; d++) set(d, 0, 1'b1, 8'(a), 8'h10 + 8'(a));
      tick();
    end

    // Write-then-read
    clr();
    set(0, 0, 1'b1, 8'd3, 8'hA5); set(1, 0, 1'b1, 8'd3, 8'hA5);
    tick();
    chk("t1 wr resp rf", rd_w[0][0], 8'h13);
    chk("t1 wr resp wf", rd_w[1][0], 8'hA5);
    clr();
    set(0, 0, 1'b0, 8'd3, 8'h00);
    tick();
    chk("t1 rd resp", rd_w[0][0], 8'hA5);
    chk("t1 rd valid", {7'b0, rv_w[0][0]}, 8'd1);

    // Same-address write collision
    clr();
    for (int d = 0; d < 2; d++) begin
      set(d, 0, 1'b1, 8'd5, 8'h11); set(d, 1, 1'b1, 8'd5, 8'h22);
    end
    tick();
    chk("t2 both valid", {6'b0, rv_w[0]}, 8'h03);
    chk("t2 loser old rf", rd_w[0][1], 8'h15);
    chk("t2 loser wf", rd_w[1][1], 8'h11);
    clr();
    for (int d = 0; d < 2; d++) begin
      set(d, 0, 1'b0, 8'd5, 8'h00); set(d, 1, 1'b0, 8'd5, 8'h00);
    end
    tick();
    chk("t2 rd p0", rd_w[0][0], 8'h11);
    chk("t2 rd p1", rd_w[0][1], 8'h11);
    chk("t2 rd wf", rd_w[1][1], 8'h11);

    // Read-during-write in both modes
    clr();
    for (int d = 0; d < 2; d++) set(d, 0, 1'b1, 8'd2, 8'h40);
    tick();
    clr();
    for (int d = 0; d < 2; d++) begin
      set(d, 1, 1'b0, 8'd2, 8'h00); set(d, 0, 1'b1, 8'd2, 8'h7E);
    end
    tick();
    chk("t3 rdw rf", rd_w[0][1], 8'h40);
    chk("t3 rdw wf", rd_w[1][1], 8'h7E);
    clr();
    for (int d = 0; d < 2; d++) set(d, 1, 1'b0, 8'd2, 8'h00);
    tick();
    chk("t3 after rf", rd_w[0][1], 8'h7E);
    chk("t3 after wf", rd_w[1][1], 8'h7E);

    // Backpressure hold
    clr();
    set(0, 0, 1'b1, 8'd1, 8'h33);
    tick();
    clr();
    set(0, 0, 1'b0, 8'd1, 8'h00);
    tick();
    chk("t4 rd", rd_w[0][0], 8'h33);
    clr();
    bp[0][0] = 1'b1;
    set(0, 0, 1'b1, 8'd1, 8'h99);
    set(0, 1, 1'b0, 8'd1, 8'h00);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4 hold resp", rd_w[0][0], 8'h33);
      chk("t4 hold valid", {7'b0, rv_w[0][0]}, 8'd1);
      chk("t4 hold bp", {7'b0, rb_w[0][0]}, 8'd1);
      chk("t4 mem intact", rd_w[0][1], 8'h33);
    end
    bp[0][0] = 1'b0;
    v[0][1] = 1'b0;
    #1;
    chk("t4 release bp", {7'b0, rb_w[0][0]}, 8'd0);
    tick();
    chk("t4 release wr resp", rd_w[0][0], 8'h33);
    clr();
    set(0, 0, 1'b0, 8'd1, 8'h00);
    tick();
    chk("t4 new data", rd_w[0][0], 8'h99);

    // Out-of-range on Depth=6
    clr();
    set(2, 0, 1'b1, 8'd7, 8'hFF);
    set(2, 1, 1'b1, 8'd6, 8'hEE);
    tick();
    chk("t5 oor wr resp", rd_w[2][0], 8'h00);
    clr();
    set(2, 0, 1'b0, 8'd7, 8'h00);
    tick();
    chk("t5 oor rd", rd_w[2][0], 8'h00);
    for (int a = 0; a < 6; a++) begin
      clr();
      set(2, 0, 1'b0, 8'(a), 8'h00);
      tick();
      chk($sformatf("t5 intact a%0d", a), rd_w[2][0], 8'h10 + 8'(a));
    end

    // Back-to-back reads at full throughput
    clr();
    for (int a = 0; a < 8; a++) begin
      set(1, 0, 1'b0, 8'(a), 8'h00);
      tick();
    end

    // Reset mid-stream
    clr();
    set(0, 0, 1'b0, 8'd3, 8'h00);
    tick();
    chk("t6 pre valid", {7'b0, rv_w[0][0]}, 8'd1);
    set(0, 0, 1'b1, 8'd4, 8'h5A);
    resetn = 1'b0;
    tick();
    chk("t6 rst valid", {7'b0, rv_w[0][0]}, 8'd0);
    chk("t6 rst resp", rd_w[0][0], 8'h00);
    chk("t6 rst bp", {7'b0, rb_w[0][0]}, 8'd1);
    resetn = 1'b1;
    clr();
    set(0, 0, 1'b0, 8'd4, 8'h00);
    tick();
    chk("t6 no write", rd_w[0][0], 8'h14);
    set(0, 0, 1'b0, 8'd3, 8'h00);
    tick();
    chk("t6 kept", rd_w[0][0], 8'hA5);
    clr();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
